calc_sequencer: RTL

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer_if.sv | 38 +++
 rtl/calc_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer_if.sv
// Key-entry, register-bank and ALU connections of the calculator sequencer.
// slave = sequencer side, master = keypad/register-bank/ALU side.
interface calc_sequencer_if;
  localparam int unsigned KEY_W   = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned STATE_W = 3;

  logic                 key_valid;
  logic [KEY_W-1:0]     key_code;
  logic [DATA_W-1:0]    alu_result;
  logic                 alu_zero;
  logic                 reg_wr_en;
  logic [ADDR_W-1:0]    reg_wr_addr;
  logic [DATA_W-1:0]    reg_wr_data;
  logic [ADDR_W-1:0]    rd_a;
  logic [ADDR_W-1:0]    rd_b;
  logic [SEL_W-1:0]     alu_sel;
  logic [DATA_W-1:0]    result;
  logic                 result_zero;
  logic                 result_valid;
  logic                 busy;
  logic                 err;
  logic [STATE_W-1:0]   state_o;

  modport slave (
    input  key_valid, key_code, alu_result, alu_zero,
    output reg_wr_en, reg_wr_addr, reg_wr_data, rd_a, rd_b, alu_sel,
           result, result_zero, result_valid, busy, err, state_o
  );

  modport master (
    output key_valid, key_code, alu_result, alu_zero,
    input  reg_wr_en, reg_wr_addr, reg_wr_data, rd_a, rd_b, alu_sel,
           result, result_zero, result_valid, busy, err, state_o
  );
endinterface

// File: rtl/calc_sequencer.sv
// Keypad-driven sequencer: loads operands into a register bank, runs one ALU op,
// writes the result back. Define CALC_CHAIN_EN to let an operator after a result reuse it as operand A.
module calc_sequencer #(
  parameter logic [1:0] A_ADDR   = 2'd0,
  parameter logic [1:0] B_ADDR   = 2'd1,
  parameter logic [1:0] RES_ADDR = 2'd2
) (
  input  logic              clk,
  input  logic              rst_n,
  calc_sequencer_if.slave   bus
);
  localparam int unsigned KEY_W   = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_A    = 3'd0;
  localparam logic [STATE_W-1:0] S_OP   = 3'd1;
  localparam logic [STATE_W-1:0] S_B    = 3'd2;
  localparam logic [STATE_W-1:0] S_EQ   = 3'd3;
  localparam logic [STATE_W-1:0] S_EXEC = 3'd4;
  localparam logic [STATE_W-1:0] S_WB   = 3'd5;
  localparam logic [STATE_W-1:0] S_RES  = 3'd6;

  logic [STATE_W-1:0] state_q,        state_nxt;
  logic [ADDR_W-1:0]  src_a_q,        src_a_nxt;
  logic [SEL_W-1:0]   alu_sel_q,      alu_sel_nxt;
  logic [DATA_W-1:0]  result_q,       result_nxt;
  logic               result_zero_q,  result_zero_nxt;
  logic               result_valid_q, result_valid_nxt;
  logic               wr_en_q,        wr_en_nxt;
  logic [ADDR_W-1:0]  wr_addr_q,      wr_addr_nxt;
  logic [DATA_W-1:0]  wr_data_q,      wr_data_nxt;
  logic               busy_q,         busy_nxt;
  logic               err_q,          err_nxt;
  logic [ADDR_W-1:0]  rd_b_q;

  logic               is_digit, is_op, is_eq, is_clr;
  logic [SEL_W-1:0]   key_sel;
  logic [DATA_W-1:0]  key_data;

  // Key classification
  always_comb begin
    is_digit = (bus.key_code <= 4'd9);
    is_op    = (bus.key_code >= 4'hA) && (bus.key_code <= 4'hD);
    is_eq    = (bus.key_code == 4'hE);
    is_clr   = (bus.key_code == 4'hF);
    key_sel  = SEL_W'(bus.key_code - 4'hA);
    key_data = {(DATA_W-KEY_W)'(0), bus.key_code};
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt        = state_q;
    src_a_nxt        = src_a_q;
    alu_sel_nxt      = alu_sel_q;
    result_nxt       = result_q;
    result_zero_nxt  = result_zero_q;
    result_valid_nxt = 1'b0;
    wr_en_nxt        = 1'b0;
    wr_addr_nxt      = '0;
    wr_data_nxt      = '0;
    err_nxt          = 1'b0;
    busy_nxt         = 1'b0;

    case (state_q)
      S_EXEC: begin
        state_nxt        = S_WB;
        result_nxt       = bus.alu_result;
        result_zero_nxt  = bus.alu_zero;
        result_valid_nxt = 1'b1;
        wr_en_nxt        = 1'b1;
        wr_addr_nxt      = RES_ADDR;
        wr_data_nxt      = bus.alu_result;
      end
      S_WB: state_nxt = S_RES;
      S_A, S_OP, S_B, S_EQ, S_RES: begin
        if (bus.key_valid && is_clr) begin
          state_nxt       = S_A;
          result_nxt      = '0;
          result_zero_nxt = 1'b0;
          alu_sel_nxt     = '0;
          src_a_nxt       = A_ADDR;
        end else if (bus.key_valid) begin
          case (state_q)
            S_A: begin
              if (is_digit) begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = A_ADDR;
                wr_data_nxt = key_data;
                state_nxt   = S_OP;
              end else begin
                err_nxt = 1'b1;
              end
            end
            S_OP: begin
              if (is_op) begin
                alu_sel_nxt = key_sel;
                state_nxt   = S_B;
              end else if (is_digit) begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = A_ADDR;
                wr_data_nxt = key_data;
              end else begin
                err_nxt = 1'b1;
              end
            end
            S_B: begin
              if (is_digit) begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = B_ADDR;
                wr_data_nxt = key_data;
                state_nxt   = S_EQ;
              end else if (is_op) begin
                alu_sel_nxt = key_sel;
              end else begin
                err_nxt = 1'b1;
              end
            end
            S_EQ: begin
              if (is_eq) begin
                state_nxt = S_EXEC;
              end else if (is_digit) begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = B_ADDR;
                wr_data_nxt = key_data;
              end else begin
                alu_sel_nxt = key_sel;
              end
            end
            default: begin
              if (is_digit) begin
                src_a_nxt   = A_ADDR;
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = A_ADDR;
                wr_data_nxt = key_data;
                state_nxt   = S_OP;
`ifdef CALC_CHAIN_EN
              end else if (is_op) begin
                alu_sel_nxt = key_sel;
                src_a_nxt   = RES_ADDR;
                state_nxt   = S_B;
`endif
              end else begin
                err_nxt = 1'b1;
              end
            end
          endcase
        end
      end
      default: state_nxt = S_A;
    endcase

    busy_nxt = (state_nxt == S_EXEC) || (state_nxt == S_WB);
  end

  // State and output registers; reset drops any pending write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_A;
      src_a_q        <= A_ADDR;
      rd_b_q         <= B_ADDR;
      alu_sel_q      <= '0;
      result_q       <= '0;
      result_zero_q  <= 1'b0;
      result_valid_q <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      src_a_q        <= src_a_nxt;
      rd_b_q         <= B_ADDR;
      alu_sel_q      <= alu_sel_nxt;
      result_q       <= result_nxt;
      result_zero_q  <= result_zero_nxt;
      result_valid_q <= result_valid_nxt;
      wr_en_q        <= wr_en_nxt;
      wr_addr_q      <= wr_addr_nxt;
      wr_data_q      <= wr_data_nxt;
      busy_q         <= busy_nxt;
      err_q          <= err_nxt;
    end
  end

  assign bus.reg_wr_en    = wr_en_q;
  assign bus.reg_wr_addr  = wr_addr_q;
  assign bus.reg_wr_data  = wr_data_q;
  assign bus.rd_a         = src_a_q;
  assign bus.rd_b         = rd_b_q;
  assign bus.alu_sel      = alu_sel_q;
  assign bus.result       = result_q;
  assign bus.result_zero  = result_zero_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;
  assign bus.state_o      = state_q;
endmodule
